// File: rtl/obstacle_pool.sv
// N-slot obstacle engine for the runner game: scroll, spawn, despawn/score and player collision,
// sequenced once per frame. Define OBSTACLE_AIRBORNE_EN to make the top type a flyer and add slot_y.
module obstacle_pool #(
    parameter int N_SLOTS     = 4,
    parameter int X_W         = 12,
    parameter int TYPE_W      = 2,
    parameter int SPAWN_X     = 640,
    parameter int DESPAWN_X   = -48,
    parameter int MIN_GAP     = 200,
    parameter int GAP_BITS    = 8,
    parameter int GROUND_Y    = 350,
    parameter int BASE_SPEED  = 4,
    parameter int SPEED_SHIFT = 4,
    parameter int MAX_SPEED   = 12,
    parameter logic [8*(1<<TYPE_W)-1:0] TYPE_WID_VEC = {8'd31, 8'd18, 8'd27, 8'd27},
    parameter logic [8*(1<<TYPE_W)-1:0] TYPE_HGT_VEC = {8'd20, 8'd17, 8'd15, 8'd15}
) (
    input  logic                       pclk,
    input  logic                       rst_n,
    input  logic                       frame_tick,
    input  logic                       run,
    input  logic                       clear,
    input  logic [15:0]                rand_in,
    input  logic [9:0]                 px,
    input  logic [9:0]                 py,
    input  logic [5:0]                 pw,
    input  logic [5:0]                 ph,
    output logic [N_SLOTS-1:0]         slot_active,
    output logic [N_SLOTS*X_W-1:0]     slot_x,
    output logic [N_SLOTS*TYPE_W-1:0]  slot_type,
`ifdef OBSTACLE_AIRBORNE_EN
    output logic [N_SLOTS*10-1:0]      slot_y,
`endif
    output logic [15:0]                score,
    output logic [4:0]                 speed,
    output logic                       collision,
    output logic [2:0]                 hit_slot,
    output logic                       frame_done,
    output logic                       overrun,
    output logic [2:0]                 dbg_state
);

    localparam int IW = $clog2(N_SLOTS);
    localparam int NT = 1 << TYPE_W;

    // frame_tick is a start strobe, accepted only in S_IDLE with run high; each accepted
    // tick yields exactly one frame_done pulse; ticks arriving while busy only set overrun.
    typedef enum logic [2:0] {S_IDLE, S_MOVE, S_SPAWN, S_CHECK, S_DONE} state_t;

    state_t                    state_q;
    logic [N_SLOTS-1:0]        slot_active_q;
    logic signed [X_W-1:0]     slot_x_q    [N_SLOTS];
    logic [TYPE_W-1:0]         slot_type_q [N_SLOTS];
    logic [15:0]               score_q;
    logic [4:0]                speed_q;
    logic                      collision_q;
    logic [2:0]                hit_slot_q;
    logic                      frame_done_q;
    logic                      overrun_q;
    logic [IW-1:0]             last_idx_q;
    logic [GAP_BITS-1:0]       gap_offset_q;
    logic [IW-1:0]             chk_idx_q;
    logic [N_SLOTS-1:0]        hit_vec_q;

    logic signed [X_W-1:0]     moved_x_d [N_SLOTS];
    logic [N_SLOTS-1:0]        moved_active_d;
    logic [3:0]                despawn_cnt;
    logic [16:0]               score_sum;
    logic [15:0]               score_d;
    logic [16:0]               speed_full;
    logic [4:0]                speed_d;
    logic [IW-1:0]             cand_idx;
    logic                      do_spawn;
    logic [7:0]                chk_w;
    logic [7:0]                chk_h;
    int                        chk_bot;
    int                        chk_x;
    logic                      hit_now;
    logic [2:0]                first_hit;
    logic                      unused_rand;

    assign unused_rand = ^rand_in;

    // Scroll step: despawned slots keep their final x so the renderer sees where they left.
    always_comb begin
        despawn_cnt = 4'd0;
        for (int i = 0; i < N_SLOTS; i++) begin
            moved_x_d[i]      = slot_x_q[i];
            moved_active_d[i] = slot_active_q[i];
            if (slot_active_q[i]) begin
                moved_x_d[i] = slot_x_q[i] - X_W'(speed_q);
                if (int'(moved_x_d[i]) < DESPAWN_X) begin
                    moved_active_d[i] = 1'b0;
                    despawn_cnt       = despawn_cnt + 4'd1;
                end
            end
        end
        score_sum  = {1'b0, score_q} + {13'd0, despawn_cnt};
        score_d    = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        speed_full = 17'(score_d >> SPEED_SHIFT) + 17'(BASE_SPEED);
        speed_d    = (speed_full > 17'(MAX_SPEED)) ? 5'(MAX_SPEED) : speed_full[4:0];
    end

    always_comb begin
        cand_idx = (last_idx_q == IW'(N_SLOTS - 1)) ? '0 : last_idx_q + IW'(1);
        do_spawn = (!slot_active_q[last_idx_q] ||
                    (int'(slot_x_q[last_idx_q]) <= SPAWN_X - MIN_GAP - int'(gap_offset_q)))
                   && !slot_active_q[cand_idx];
    end

    always_comb begin
        chk_w   = 8'd0;
        chk_h   = 8'd0;
        chk_bot = GROUND_Y;
        for (int t = 0; t < NT; t++) begin
            if (slot_type_q[chk_idx_q] == TYPE_W'(t)) begin
                chk_w = TYPE_WID_VEC[8*t +: 8];
                chk_h = TYPE_HGT_VEC[8*t +: 8];
            end
        end
`ifdef OBSTACLE_AIRBORNE_EN
        if (slot_type_q[chk_idx_q] == TYPE_W'(NT - 1))
            chk_bot = GROUND_Y - 24;
`endif
        chk_x   = int'(slot_x_q[chk_idx_q]);
        hit_now = slot_active_q[chk_idx_q]
                  && (chk_x < int'(px) + int'(pw))
                  && (int'(px) < chk_x + int'(chk_w))
                  && (chk_bot - int'(chk_h) < int'(py) + int'(ph))
                  && (int'(py) < chk_bot);
    end

    always_comb begin
        first_hit = 3'd0;
        for (int i = N_SLOTS - 1; i >= 0; i--)
            if (hit_vec_q[i]) first_hit = 3'(i);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            slot_active_q <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                slot_x_q[i]    <= '0;
                slot_type_q[i] <= '0;
            end
            score_q       <= '0;
            speed_q       <= 5'(BASE_SPEED);
            collision_q   <= 1'b0;
            hit_slot_q    <= '0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            last_idx_q    <= IW'(N_SLOTS - 1);
            gap_offset_q  <= '0;
            chk_idx_q     <= '0;
            hit_vec_q     <= '0;
        end else if (clear) begin
            state_q       <= S_IDLE;
            slot_active_q <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                slot_x_q[i]    <= '0;
                slot_type_q[i] <= '0;
            end
            score_q       <= '0;
            speed_q       <= 5'(BASE_SPEED);
            collision_q   <= 1'b0;
            hit_slot_q    <= '0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            last_idx_q    <= IW'(N_SLOTS - 1);
            gap_offset_q  <= '0;
            chk_idx_q     <= '0;
            hit_vec_q     <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (frame_tick && state_q != S_IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (frame_tick && run)
                        state_q <= S_MOVE;
                end
                S_MOVE: begin
                    for (int i = 0; i < N_SLOTS; i++)
                        slot_x_q[i] <= moved_x_d[i];
                    slot_active_q <= moved_active_d;
                    score_q       <= score_d;
                    speed_q       <= speed_d;
                    state_q       <= S_SPAWN;
                end
                S_SPAWN: begin
                    if (do_spawn) begin
                        slot_x_q[cand_idx]      <= X_W'(SPAWN_X);
                        slot_type_q[cand_idx]   <= rand_in[TYPE_W-1:0];
                        slot_active_q[cand_idx] <= 1'b1;
                        last_idx_q              <= cand_idx;
                        gap_offset_q            <= rand_in[GAP_BITS+7:8];
                    end
                    chk_idx_q <= '0;
                    hit_vec_q <= '0;
                    state_q   <= S_CHECK;
                end
                S_CHECK: begin
                    hit_vec_q[chk_idx_q] <= hit_now;
                    if (chk_idx_q == IW'(N_SLOTS - 1))
                        state_q <= S_DONE;
                    else
                        chk_idx_q <= chk_idx_q + IW'(1);
                end
                S_DONE: begin
                    collision_q  <= |hit_vec_q;
                    hit_slot_q   <= first_hit;
                    frame_done_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_pack
        assign slot_x[g*X_W +: X_W]          = slot_x_q[g];
        assign slot_type[g*TYPE_W +: TYPE_W] = slot_type_q[g];
`ifdef OBSTACLE_AIRBORNE_EN
        assign slot_y[g*10 +: 10] = (slot_type_q[g] == TYPE_W'(NT - 1)) ? 10'(GROUND_Y - 24)
                                                                        : 10'(GROUND_Y);
`endif
    end

    assign slot_active = slot_active_q;
    assign score       = score_q;
    assign speed       = speed_q;
    assign collision   = collision_q;
    assign hit_slot    = hit_slot_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_obstacle_pool.sv
// Scoreboard bench for obstacle_pool: per-frame expected snapshots queued by the driver,
// popped and compared by a monitor on every frame_done.
module tb_obstacle_pool;
  localparam int N  = 4;
  localparam int XW = 12;
  localparam int TW = 2;
  localparam int VW = N + N*XW + N*TW + 16 + 5 + 1 + 3;
  localparam int W  = VW + 17;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] rand_in = 16'd0;
  logic [9:0]  px = 10'd80;
  logic [9:0]  py = 10'd332;
  logic [5:0]  pw = 6'd18;
  logic [5:0]  ph = 6'd18;

  logic [N-1:0]    slot_active;
  logic [N*XW-1:0] slot_x;
  logic [N*TW-1:0] slot_type;
`ifdef OBSTACLE_AIRBORNE_EN
  logic [N*10-1:0] slot_y;
`endif
  logic [15:0]     score;
  logic [4:0]      speed;
  logic            collision;
  logic [2:0]      hit_slot;
  logic            frame_done;
  logic            overrun;
  logic [2:0]      dbg_state;

  logic [VW-1:0]   act_v;
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    mon_ent;
  int              checks = 0;
  int              passed = 0;

  obstacle_pool dut (
    .pclk(pclk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .clear(clear),
    .rand_in(rand_in), .px(px), .py(py), .pw(pw), .ph(ph),
    .slot_active(slot_active), .slot_x(slot_x), .slot_type(slot_type),
`ifdef OBSTACLE_AIRBORNE_EN
    .slot_y(slot_y),
`endif
    .score(score), .speed(speed), .collision(collision), .hit_slot(hit_slot),
    .frame_done(frame_done), .overrun(overrun), .dbg_state(dbg_state)
  );

  assign act_v = {slot_active, slot_x, slot_type, score, speed, collision, hit_slot};

  // clock
  always #5 pclk = ~pclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] mk(logic [3:0] act, int x0, int x1, int x2, int x3,
                                       logic [7:0] typ, int sc, logic col, int hit);
    logic [11:0] a0 = 12'(x0);
    logic [11:0] a1 = 12'(x1);
    logic [11:0] a2 = 12'(x2);
    logic [11:0] a3 = 12'(x3);
    return {act, a3, a2, a1, a0, typ, 16'(sc), 5'd4, col, 3'(hit)};
  endfunction

  // hand-computed snapshots; phase 0 = first run (py=332), 1 = after clear (py=300), 2 = after reset
  function automatic logic [W-1:0] get_ent(int phase, int f);
    logic [VW-1:0] v = '0;
    logic chk = 1'b1;
    case (phase*1000 + f)
      1:    v = mk(4'b0001, 640,   0,   0,   0, 8'h00, 0, 1'b0, 0);
      51:   v = mk(4'b0011, 440, 640,   0,   0, 8'h00, 0, 1'b0, 0);
      101:  v = mk(4'b0111, 240, 440, 640,   0, 8'h00, 0, 1'b0, 0);
      136:  v = mk(4'b0111, 100, 300, 500,   0, 8'h00, 0, 1'b0, 0);
      137:  v = mk(4'b0111,  96, 296, 496,   0, 8'h00, 0, 1'b1, 0);
      151:  v = mk(4'b1111,  40, 240, 440, 640, 8'h00, 0, 1'b0, 0);
      173:  v = mk(4'b1111, -48, 152, 352, 552, 8'h00, 0, 1'b0, 0);
      174:  v = mk(4'b1110, -52, 148, 348, 548, 8'h00, 1, 1'b0, 0);
      200:  v = mk(4'b1110, -52,  44, 244, 444, 8'h00, 1, 1'b0, 0);
      201:  v = mk(4'b1111, 640,  40, 240, 440, 8'h00, 1, 1'b0, 0);
      202:  v = mk(4'b1111, 636,  36, 236, 436, 8'h00, 1, 1'b0, 0);
      1137: v = mk(4'b0111,  96, 296, 496,   0, 8'h00, 0, 1'b0, 0);
      1140: v = mk(4'b0111,  84, 284, 484,   0, 8'h00, 0, 1'b0, 0);
      2001: v = mk(4'b0001, 640,   0,   0,   0, 8'h02, 0, 1'b0, 0);
      2051: v = mk(4'b0001, 440,   0,   0,   0, 8'h02, 0, 1'b0, 0);
      2052: v = mk(4'b0011, 436, 640,   0,   0, 8'h02, 0, 1'b0, 0);
      default: chk = 1'b0;
    endcase
    return {chk, 16'(phase*1000 + f), v};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // one frame; ovr_at > 0 injects an extra tick that many cycles into the sequence
  task automatic do_frame(input int phase, input int f, input int ovr_at);
    int cnt;
    @(negedge pclk);
    exp_q.push_back(get_ent(phase, f));
    frame_tick = 1'b1;
    @(negedge pclk);
    frame_tick = 1'b0;
    cnt = 0;
    while (!frame_done && cnt < 20) begin
      @(negedge pclk);
      cnt++;
      frame_tick = (cnt == ovr_at);
    end
    frame_tick = 1'b0;
    check($sformatf("latency_p%0d_f%0d", phase, f), cnt, 7);
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      @(negedge pclk);
      if (frame_done) seen = 1'b1;
    end
    check(name, seen, 0);
  endtask

  // scoreboard monitor
  always @(negedge pclk) begin
    if (frame_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_frame_done: got pulse at %0t required none", $time);
      end else begin
        mon_ent = exp_q.pop_front();
        if (mon_ent[W-1]) begin
          checks++;
          if (act_v === mon_ent[VW-1:0]) passed++;
          else $display("FAIL frame_%0d: got %h expected %h",
                        mon_ent[VW+15:VW], act_v, mon_ent[VW-1:0]);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
    check("rst_active", slot_active, 0);
    check("rst_score", score, 0);
    check("rst_speed", speed, 4);
    check("rst_collision", collision, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dbg_state, 0);

    // tick while not running is ignored
    frame_tick = 1'b1;
    @(negedge pclk);
    frame_tick = 1'b0;
    watch_no_done("run0_no_done", 12);
    check("run0_state", dbg_state, 0);

    clear = 1'b1;
    @(negedge pclk);
    clear = 1'b0;
    run = 1'b1;

    for (int f = 1; f <= 201; f++) do_frame(0, f, -1);
    check("overrun_before", overrun, 0);
    do_frame(0, 202, 3);
    check("overrun_sticky", overrun, 1);

    // clear during CHECK aborts the frame
    @(negedge pclk);
    frame_tick = 1'b1;
    @(negedge pclk);
    frame_tick = 1'b0;
    repeat (3) @(negedge pclk);
    clear = 1'b1;
    @(negedge pclk);
    clear = 1'b0;
    check("clr_active", slot_active, 0);
    check("clr_score", score, 0);
    check("clr_speed", speed, 4);
    check("clr_overrun", overrun, 0);
    check("clr_state", dbg_state, 0);
    watch_no_done("clr_no_done", 12);

    py = 10'd300;
    for (int f = 1; f <= 140; f++) do_frame(1, f, -1);

    // asynchronous reset during MOVE
    @(negedge pclk);
    frame_tick = 1'b1;
    @(negedge pclk);
    frame_tick = 1'b0;
    check("pre_rst_state", dbg_state, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_active", slot_active, 0);
    check("arst_x", slot_x, 0);
    check("arst_state", dbg_state, 0);
    check("arst_speed", speed, 4);
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;

    rand_in = 16'h0302;
    do_frame(2, 1, -1);
    rand_in = 16'h0000;
    for (int f = 2; f <= 52; f++) do_frame(2, f, -1);

    repeat (3) @(negedge pclk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/obstacle_pool.md
Name: obstacle_pool

Overview:
- Parametrised N-slot obstacle engine for the runner game. Owns obstacle positions, spawning, scrolling, despawn/scoring and player collision.
- Per-frame work runs as a multi-cycle sequence on pclk, triggered by a one-cycle frame_tick from the VGA vsync edge detector.
- Sits between the game-state FSM (drives run/clear) and the sprite renderer (reads slot_x/slot_type/slot_active).

Parameters:
N_SLOTS, 4, obstacle slots (2..8)
X_W, 12, signed x-position width
TYPE_W, 2, obstacle type code width
SPAWN_X, 640, x written into a newly spawned slot
DESPAWN_X, -48, slot freed when x < DESPAWN_X (signed)
MIN_GAP, 200, minimum pixel spacing between consecutive spawns
GAP_BITS, 8, random extra gap width (0..2^GAP_BITS-1)
GROUND_Y, 350, obstacle bottom edge is GROUND_Y-1
BASE_SPEED, 4, pixels per frame at score 0
SPEED_SHIFT, 4, speed = BASE_SPEED + (score >> SPEED_SHIFT)
MAX_SPEED, 12, speed clamp
TYPE_WID_VEC / TYPE_HGT_VEC, {31,18,27,27}/{20,17,15,15} packed 8b, per-type width/height (index = type)

Ports:
pclk  in  1  system clock
rst_n  in  1  reset. Asynchronous, active-low.
frame_tick  in  1  one-cycle pulse per frame
run  in  1  high while game in RUN state
clear  in  1  synchronous restart to reset state
rand_in  in  16  free-running LFSR value
px, py  in  10 each  player box top-left
pw, ph  in  6 each  player box size
slot_active  out  N_SLOTS  per-slot valid
slot_x  out  N_SLOTS*X_W  packed signed x, slot 0 in LSBs
slot_type  out  N_SLOTS*TYPE_W  packed type
score  out  16  obstacles passed, saturating at 16'hFFFF
speed  out  5  current scroll speed
collision  out  1  registered, valid with frame_done
hit_slot  out  3  lowest colliding slot index
frame_done  out  1  one-cycle pulse ending each frame sequence
overrun  out  1  sticky: frame_tick arrived while busy

Behaviour:
- Reset (rst_n low) and clear: all outputs 0, speed=BASE_SPEED, FSM IDLE, last_idx=N_SLOTS-1, gap_offset=0. clear overrides every other event in the same cycle, including mid-sequence; no frame_done is emitted for an aborted sequence.
- FSM: IDLE -> MOVE -> SPAWN -> CHECK (N_SLOTS cycles, one slot per cycle) -> DONE -> IDLE.
  - frame_tick with run=1 in IDLE starts the sequence. frame_done is high exactly N_SLOTS+3 cycles after the tick cycle.
  - frame_tick while run=0: ignored, state frozen.
  - frame_tick outside IDLE: ignored, overrun<=1 until reset/clear.
- MOVE, per active slot: x <= x - speed (signed, X_W bits). If the new x < DESPAWN_X: slot_active<=0 and score+1 (saturating).
  - Multiple despawns in one frame add their count.
  - speed is recomputed from the updated score and clamped to MAX_SPEED.
- SPAWN, candidate n = (last_idx+1) mod N_SLOTS:
  - Spawn condition: slot last_idx is inactive, OR its x <= SPAWN_X - MIN_GAP - gap_offset.
  - If the condition holds and candidate is free: x=SPAWN_X, type=rand_in[TYPE_W-1:0], active=1, last_idx<=n, gap_offset<=rand_in[GAP_BITS+7:8].
  - If the candidate is busy (pool full), the spawn is skipped this frame and retried next frame.
  - An empty pool spawns on the first frame. A freshly spawned slot does not move until the next frame.
- CHECK, per slot i (active only): obstacle box [x, x+w) x [GROUND_Y-h, GROUND_Y) against player [px, px+pw) x [py, py+ph).
  - Overlap is strict, signed compare on x.
  - collision and hit_slot update only in DONE, from the positions after MOVE/SPAWN.
  - collision holds its value until the next DONE or clear.

Optional Feature:
OBSTACLE_AIRBORNE_EN:
- Defined: type 2^TYPE_W-1 is a flyer whose box bottom is GROUND_Y-24 instead of GROUND_Y; slot_y output (N_SLOTS*10, packed bottom edge) is added for the renderer.
- Undefined: all types grounded, no slot_y port.

Test Plan:
- clear, run=1, rand_in=0, one frame_tick -> frame_done 7 cycles later; slot_active=4'b0001, slot_x[0]=640, type 0, score 0, speed 4.
- 50 further ticks, rand_in=0 -> slot0 x=440; slot1 spawns on that same frame at 640; slot2 spawns on frame 101.
- Continue to frame 174 -> slot0 x reaches -52 < -48: slot0 inactive, score=1. Frame 201 respawns slot0 at 640.
- Player px=80, py=332, pw=18, ph=18, type 0 (27x15) -> collision=1, hit_slot=0 first at slot0 x=96 (frame 137); with py=300 -> collision stays 0.
- frame_tick during CHECK -> overrun=1, sequence unaffected; clear during CHECK -> next cycle all slots inactive, score 0, no frame_done.
- rst_n low asynchronously mid-MOVE -> outputs 0 immediately, without waiting for a pclk edge; first tick after release behaves as the first scenario.
